wbmem_loader: RTL and testbench
===============================

Name: wbmem_loader

Overview:
- Write-side counterpart of the weight/bias memory bank.
- Receives a bank-major stream of 32-bit words from the picoRV32 side over a valid/ready handshake.
- Issues one registered write per accepted word to the 42-bank memory write port (banks 0-31 hold [W1|b1], banks 32-41 hold [W2|b2]), so weights can be reloaded at run time without $readmemh.
- Signals busy while loading and pulses done at completion.

Parameters:
- NBANK_L1, 32: number of layer-1 banks, one per hidden neuron.
- NBANK_L2, 10: number of layer-2 banks, one per output class.
- L1_WORDS, 785: words per layer-1 bank (784 weights + 1 bias).
- L2_WORDS, 33: words per layer-2 bank (32 weights + 1 bias).
- AW, 10: bank address width (depth 1024).

Ports:
- clk      in   1   system clock
- resetn   in   1   asynchronous active-low reset
- start    in   1   single-cycle pulse; begins a full load when idle
- s_valid  in   1   stream word valid
- s_ready  out  1   loader accepts a word this cycle
- s_data   in   32  stream word
- wr_en    out  1   memory write strobe
- wr_bank  out  6   target bank, 0..NBANK_L1+NBANK_L2-1
- wr_addr  out  AW  word address within bank
- wr_data  out  32  write data
- busy     out  1   load in progress
- done     out  1   one-cycle pulse on completion

Behaviour:
- Reset is asynchronous active-low. The following are all 0 while resetn=0 and in the first cycle after release: s_ready, wr_en, wr_bank, wr_addr, wr_data, busy, done. State is IDLE and internal bank/addr counters are 0.
- States and transitions:
  - IDLE -> L1 on start=1. Counters clear to bank=0, addr=0.
  - L1 -> L2 after the last layer-1 word is accepted.
  - L2 -> FIN after the last layer-2 word is accepted.
  - FIN -> IDLE unconditionally after one cycle.
- s_ready = 1 exactly in L1 and L2, decoded from registered state. It is 0 in IDLE and FIN.
- Accept = s_valid & s_ready. Only accepted words advance the counters. s_valid gaps hold all counters. s_data is ignored when not accepted.
- Write latency is 1 cycle. The cycle after an accept, wr_en=1 with wr_data = the accepted word and wr_bank/wr_addr = the counters at accept time. Otherwise wr_en=0. wr_bank, wr_addr and wr_data hold their last values.
- Counter update in L1, on accept:
  - addr==L1_WORDS-1: addr->0, bank->bank+1. If bank==NBANK_L1-1, go to L2 with bank=NBANK_L1.
  - Otherwise addr->addr+1.
- Counter update in L2, on accept:
  - addr==L2_WORDS-1: addr->0. If bank==NBANK_L1+NBANK_L2-1, go to FIN; otherwise bank->bank+1.
  - Otherwise addr->addr+1.
- Stream order: bank 0 addr 0..784, bank 1 addr 0..784, ..., bank 31, then bank 32 addr 0..32, ..., bank 41. Total words with defaults = 32*785 + 10*33 = 25450.
- busy = 1 in L1, L2 and FIN; 0 in IDLE. It is registered, so it rises the cycle after start.
- done = 1 only in FIN. This is the same cycle as the final wr_en (bank 41, addr 32). busy drops to 0 the next cycle.
- start while not in IDLE is ignored, including in FIN. There is no restart mid-load.
- Back-to-back: start asserted in the first IDLE cycle after FIN begins a new load.
- resetn low mid-load aborts immediately: all outputs go to reset values and any pending write is dropped. Words already written remain in memory and no cleanup is performed.
- Widths:
  - addr counter is AW bits; bank counter is 6 bits.
  - Parameter legality: L1_WORDS and L2_WORDS ≤ 2^AW; NBANK_L1+NBANK_L2 ≤ 64. Checked at elaboration.

Test Plan:
- Reset/idle: hold resetn=0 for 3 cycles, then release with s_valid=1 and no start -> s_ready, wr_en, busy and done stay 0 for 10 cycles; no writes.
- Full load, defaults: start pulse, then stream words = index 0..25449 with s_valid=1 every cycle ->
  - 25450 writes.
  - First write: bank 0, addr 0, data 0.
  - Write #785: bank 1, addr 0, data 785.
  - Write #25120: bank 32, addr 0, data 25120.
  - Last write: bank 41, addr 32, data 25449, with done=1 in that cycle.
  - busy=0 on the following cycle.
- Throttled stream: NBANK_L1=2, NBANK_L2=1, L1_WORDS=3, L2_WORDS=2, s_valid toggling 1,0,1,0 -> 8 writes in order (0,0),(0,1),(0,2),(1,0),(1,1),(1,2),(2,0),(2,1). Each write exactly 1 cycle after its accept; no writes in gap cycles.
- Start while busy: pulse start again at word 100 -> ignored; counters continue; total still 25450 writes.
- Reset mid-load: assert resetn=0 asynchronously after word 40000/2=20000 is accepted -> outputs go to 0 without waiting for a clk edge. After release, a new start writes bank 0, addr 0 first.
- Back-to-back loads: start in the first cycle after done -> second load begins with bank 0, addr 0; busy high again one cycle later.

Source files
------------

// File: rtl/wbmem_loader_if.sv
// Stream-in / memory-write-out bundle for the weight/bias loader.
interface wbmem_loader_if #(
    parameter int unsigned AW = 10
) ();
    logic          start;
    logic          s_valid;
    logic          s_ready;
    logic [31:0]   s_data;
    logic          wr_en;
    logic [5:0]    wr_bank;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          busy;
    logic          done;

    modport master (
        output start, s_valid, s_data,
        input  s_ready, wr_en, wr_bank, wr_addr, wr_data, busy, done
    );

    modport slave (
        input  start, s_valid, s_data,
        output s_ready, wr_en, wr_bank, wr_addr, wr_data, busy, done
    );
endinterface

// File: rtl/wbmem_loader.sv
// Loads a bank-major word stream into the 42-bank weight/bias memory write port.
module wbmem_loader #(
    parameter int unsigned NBANK_L1 = 32,
    parameter int unsigned NBANK_L2 = 10,
    parameter int unsigned L1_WORDS = 785,
    parameter int unsigned L2_WORDS = 33,
    parameter int unsigned AW       = 10
) (
    input  logic           clk,
    input  logic           resetn,
    wbmem_loader_if.slave  bus
);
    localparam int unsigned BW = 6;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_L1   = 2'd1;
    localparam logic [1:0] ST_L2   = 2'd2;
    localparam logic [1:0] ST_FIN  = 2'd3;

    localparam logic [AW-1:0] L1_LAST_ADDR = AW'(L1_WORDS - 1);
    localparam logic [AW-1:0] L2_LAST_ADDR = AW'(L2_WORDS - 1);
    localparam logic [BW-1:0] L1_LAST_BANK = BW'(NBANK_L1 - 1);
    localparam logic [BW-1:0] L2_LAST_BANK = BW'(NBANK_L1 + NBANK_L2 - 1);

    // Reject geometries that do not fit the address or bank counters
    if ((L1_WORDS > (32'd1 << AW)) || (L2_WORDS > (32'd1 << AW)) ||
        (L1_WORDS == 0) || (L2_WORDS == 0) || (NBANK_L1 == 0) || (NBANK_L2 == 0) ||
        ((NBANK_L1 + NBANK_L2) > 64)) begin : g_bad_params
        $error("wbmem_loader: illegal bank/word parameters");
    end

    logic [1:0]    state_q,   state_d;
    logic [BW-1:0] bank_q,    bank_d;
    logic [AW-1:0] addr_q,    addr_d;
    logic          wr_en_q,   wr_en_d;
    logic [BW-1:0] wr_bank_q, wr_bank_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]   wr_data_q, wr_data_d;
    logic          s_ready_c;
    logic          accept_c;

    // Handshake and status are pure decodes of the registered state
    assign s_ready_c   = (state_q == ST_L1) || (state_q == ST_L2);
    assign accept_c    = bus.s_valid & s_ready_c;
    assign bus.s_ready = s_ready_c;
    assign bus.busy    = (state_q != ST_IDLE);
    assign bus.done    = (state_q == ST_FIN);
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_bank = wr_bank_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;

    // Next-state, counter advance and write-port capture
    always_comb begin
        state_d   = state_q;
        bank_d    = bank_q;
        addr_d    = addr_q;
        wr_en_d   = 1'b0;
        wr_bank_d = wr_bank_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        if (accept_c) begin
            wr_en_d   = 1'b1;
            wr_bank_d = bank_q;
            wr_addr_d = addr_q;
            wr_data_d = bus.s_data;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_L1;
                    bank_d  = '0;
                    addr_d  = '0;
                end
            end
            ST_L1: begin
                if (accept_c) begin
                    if (addr_q == L1_LAST_ADDR) begin
                        addr_d = '0;
                        bank_d = bank_q + BW'(1);
                        if (bank_q == L1_LAST_BANK) begin
                            state_d = ST_L2;
                        end
                    end else begin
                        addr_d = addr_q + AW'(1);
                    end
                end
            end
            ST_L2: begin
                if (accept_c) begin
                    if (addr_q == L2_LAST_ADDR) begin
                        addr_d = '0;
                        if (bank_q == L2_LAST_BANK) begin
                            state_d = ST_FIN;
                        end else begin
                            bank_d = bank_q + BW'(1);
                        end
                    end else begin
                        addr_d = addr_q + AW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and write port; reset drops any pending write
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            bank_q    <= '0;
            addr_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_bank_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            bank_q    <= bank_d;
            addr_q    <= addr_d;
            wr_en_q   <= wr_en_d;
            wr_bank_q <= wr_bank_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end
endmodule

// File: tb/tb_wbmem_loader.sv
// Bench for wbmem_loader: default geometry (dut_a) and a tiny geometry (dut_b).
module tb_wbmem_loader;
    localparam int unsigned AW = 10;
    localparam int A_NL1 = 32, A_NL2 = 10, A_L1W = 785, A_L2W = 33;
    localparam int A_TOTAL = A_NL1 * A_L1W + A_NL2 * A_L2W;
    localparam int B_NL1 = 2, B_NL2 = 1, B_L1W = 3, B_L2W = 2;
    localparam int B_TOTAL = B_NL1 * B_L1W + B_NL2 * B_L2W;

    logic clk = 1'b0;
    logic resetn_a, resetn_b;
    int   n_tests = 0;
    int   n_fail  = 0;

    wbmem_loader_if #(.AW(AW)) bus_a ();
    wbmem_loader_if #(.AW(AW)) bus_b ();

    wbmem_loader #(.NBANK_L1(A_NL1), .NBANK_L2(A_NL2), .L1_WORDS(A_L1W), .L2_WORDS(A_L2W), .AW(AW))
        dut_a (.clk(clk), .resetn(resetn_a), .bus(bus_a));
    wbmem_loader #(.NBANK_L1(B_NL1), .NBANK_L2(B_NL2), .L1_WORDS(B_L1W), .L2_WORDS(B_L2W), .AW(AW))
        dut_b (.clk(clk), .resetn(resetn_b), .bus(bus_b));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    // Position of the k-th stream word, straight from the bank-major ordering
    function automatic int exp_bank(input int k, input int nl1, input int l1w, input int l2w);
        if (k < nl1 * l1w) return k / l1w;
        return nl1 + (k - nl1 * l1w) / l2w;
    endfunction
    function automatic int exp_addr(input int k, input int nl1, input int l1w, input int l2w);
        if (k < nl1 * l1w) return k % l1w;
        return (k - nl1 * l1w) % l2w;
    endfunction

    // Reference model: loading flag, word count, final-cycle flag, pending write
    logic ma_act, ma_fin, ma_wen;  int ma_k;
    logic [5:0] ma_wb; logic [AW-1:0] ma_wa; logic [31:0] ma_wd;
    always @(posedge clk or negedge resetn_a) begin
        if (!resetn_a) begin
            ma_act <= 0; ma_fin <= 0; ma_wen <= 0; ma_k <= 0; ma_wb <= 0; ma_wa <= 0; ma_wd <= 0;
        end else begin
            ma_wen <= 0; ma_fin <= 0;
            if (!ma_act && !ma_fin && bus_a.start) begin ma_act <= 1; ma_k <= 0; end
            if (ma_act && bus_a.s_valid) begin
                ma_wen <= 1;
                ma_wb  <= 6'(exp_bank(ma_k, A_NL1, A_L1W, A_L2W));
                ma_wa  <= AW'(exp_addr(ma_k, A_NL1, A_L1W, A_L2W));
                ma_wd  <= bus_a.s_data;
                ma_k   <= ma_k + 1;
                if (ma_k == A_TOTAL - 1) begin ma_act <= 0; ma_fin <= 1; end
            end
        end
    end

    logic mb_act, mb_fin, mb_wen;  int mb_k;
    logic [5:0] mb_wb; logic [AW-1:0] mb_wa; logic [31:0] mb_wd;
    always @(posedge clk or negedge resetn_b) begin
        if (!resetn_b) begin
            mb_act <= 0; mb_fin <= 0; mb_wen <= 0; mb_k <= 0; mb_wb <= 0; mb_wa <= 0; mb_wd <= 0;
        end else begin
            mb_wen <= 0; mb_fin <= 0;
            if (!mb_act && !mb_fin && bus_b.start) begin mb_act <= 1; mb_k <= 0; end
            if (mb_act && bus_b.s_valid) begin
                mb_wen <= 1;
                mb_wb  <= 6'(exp_bank(mb_k, B_NL1, B_L1W, B_L2W));
                mb_wa  <= AW'(exp_addr(mb_k, B_NL1, B_L1W, B_L2W));
                mb_wd  <= bus_b.s_data;
                mb_k   <= mb_k + 1;
                if (mb_k == B_TOTAL - 1) begin mb_act <= 0; mb_fin <= 1; end
            end
        end
    end

    int   phase = 0;
    int   base_a = 0, wcnt_a = 0, wcnt_b = 0;
    int   idx_a = 0;
    logic chk_busy_low = 1'b0;

    // Per-cycle comparison of dut_a against the model, plus pinned write positions
    always @(negedge clk) begin : mon_a
        int rel;
        check("a_s_ready", 64'(bus_a.s_ready), 64'(ma_act));
        check("a_busy",    64'(bus_a.busy),    64'(ma_act | ma_fin));
        check("a_done",    64'(bus_a.done),    64'(ma_fin));
        check("a_wr_en",   64'(bus_a.wr_en),   64'(ma_wen));
        check("a_wr_bank", 64'(bus_a.wr_bank), 64'(ma_wb));
        check("a_wr_addr", 64'(bus_a.wr_addr), 64'(ma_wa));
        check("a_wr_data", 64'(bus_a.wr_data), 64'(ma_wd));
        if (chk_busy_low) begin
            check("a_busy_after_done", 64'(bus_a.busy), 64'd0);
            chk_busy_low = 1'b0;
        end
        if (bus_a.wr_en) begin
            rel = wcnt_a - base_a;
            if (rel == 0) begin
                check("a_first_bank", 64'(bus_a.wr_bank), 64'd0);
                check("a_first_addr", 64'(bus_a.wr_addr), 64'd0);
                check("a_first_data", 64'(bus_a.wr_data), 64'd0);
            end
            if (phase == 1 && rel == 785) begin
                check("a_w785_bank", 64'(bus_a.wr_bank), 64'd1);
                check("a_w785_addr", 64'(bus_a.wr_addr), 64'd0);
                check("a_w785_data", 64'(bus_a.wr_data), 64'd785);
            end
            if (phase == 1 && rel == 25120) begin
                check("a_w25120_bank", 64'(bus_a.wr_bank), 64'd32);
                check("a_w25120_addr", 64'(bus_a.wr_addr), 64'd0);
                check("a_w25120_data", 64'(bus_a.wr_data), 64'd25120);
            end
            if (phase == 1 && rel == 25449) begin
                check("a_last_bank", 64'(bus_a.wr_bank), 64'd41);
                check("a_last_addr", 64'(bus_a.wr_addr), 64'd32);
                check("a_last_data", 64'(bus_a.wr_data), 64'd25449);
                check("a_last_done", 64'(bus_a.done),    64'd1);
                chk_busy_low = 1'b1;
            end
            wcnt_a++;
        end
    end

    // Per-cycle comparison of dut_b, plus the hand-written write order
    always @(negedge clk) begin : mon_b
        logic [5:0]    tb_bank [8];
        logic [AW-1:0] tb_addr [8];
        tb_bank = '{6'd0, 6'd0, 6'd0, 6'd1, 6'd1, 6'd1, 6'd2, 6'd2};
        tb_addr = '{10'd0, 10'd1, 10'd2, 10'd0, 10'd1, 10'd2, 10'd0, 10'd1};
        check("b_s_ready", 64'(bus_b.s_ready), 64'(mb_act));
        check("b_busy",    64'(bus_b.busy),    64'(mb_act | mb_fin));
        check("b_done",    64'(bus_b.done),    64'(mb_fin));
        check("b_wr_en",   64'(bus_b.wr_en),   64'(mb_wen));
        check("b_wr_bank", 64'(bus_b.wr_bank), 64'(mb_wb));
        check("b_wr_addr", 64'(bus_b.wr_addr), 64'(mb_wa));
        check("b_wr_data", 64'(bus_b.wr_data), 64'(mb_wd));
        if (bus_b.wr_en) begin
            if (wcnt_b < 8) begin
                check("b_tbl_bank", 64'(bus_b.wr_bank), 64'(tb_bank[wcnt_b]));
                check("b_tbl_addr", 64'(bus_b.wr_addr), 64'(tb_addr[wcnt_b]));
                check("b_tbl_data", 64'(bus_b.wr_data), 64'(32'hA0 + 32'(wcnt_b)));
            end
            if (wcnt_b == 7) check("b_last_done", 64'(bus_b.done), 64'd1);
            wcnt_b++;
        end
    end

    // Continuous stream into dut_a until n_acc words are accepted
    task automatic stream_a(input int n_acc, input int start_at);
        int guard = 0;
        while (idx_a < n_acc && guard < 40000) begin
            bus_a.s_valid = 1'b1;
            bus_a.s_data  = 32'(idx_a);
            bus_a.start   = (idx_a == start_at);
            @(negedge clk);
            if (bus_a.s_ready) idx_a++;
            @(posedge clk); #1;
            guard++;
        end
        bus_a.s_valid = 1'b0;
        bus_a.start   = 1'b0;
        check("a_stream_progress", 64'(idx_a), 64'(n_acc));
    endtask

    initial begin
        int idx_b, guard_b;
        resetn_a = 1'b0; resetn_b = 1'b0;
        bus_a.start = 0; bus_a.s_valid = 0; bus_a.s_data = 0;
        bus_b.start = 0; bus_b.s_valid = 0; bus_b.s_data = 0;

        // Reset held for three cycles, then idle with s_valid high and no start
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", 64'(bus_a.s_ready), 64'd0);
        check("rst_wr_en",   64'(bus_a.wr_en),   64'd0);
        check("rst_busy",    64'(bus_a.busy),    64'd0);
        check("rst_done",    64'(bus_a.done),    64'd0);
        bus_a.s_valid = 1'b1; bus_b.s_valid = 1'b1;
        #4;
        resetn_a = 1'b1; resetn_b = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("idle_no_writes", 64'(wcnt_a), 64'd0);
        bus_a.s_valid = 1'b0; bus_b.s_valid = 1'b0;

        // Throttled stream on the small geometry
        bus_b.start = 1'b1;
        @(posedge clk); #1;
        bus_b.start = 1'b0;
        idx_b = 0; guard_b = 0;
        while (idx_b < B_TOTAL && guard_b < 100) begin
            bus_b.s_valid = (guard_b % 2 == 0);
            bus_b.s_data  = bus_b.s_valid ? 32'hA0 + 32'(idx_b) : 32'hDEAD_BEEF;
            @(negedge clk);
            if (bus_b.s_valid && bus_b.s_ready) idx_b++;
            @(posedge clk); #1;
            guard_b++;
        end
        bus_b.s_valid = 1'b0;
        check("b_stream_progress", 64'(idx_b), 64'(B_TOTAL));
        repeat (4) @(posedge clk);
        #1;
        check("b_total_writes", 64'(wcnt_b), 64'(B_TOTAL));
        check("b_idle_busy", 64'(bus_b.busy), 64'd0);

        // Full default load with an ignored start at word 100
        phase = 1; base_a = wcnt_a;
        bus_a.start = 1'b1;
        @(posedge clk); #1;
        bus_a.start = 1'b0;
        check("a_busy_after_start", 64'(bus_a.busy), 64'd1);
        idx_a = 0;
        stream_a(A_TOTAL, 100);

        // Back-to-back: start in the first idle cycle after done
        @(posedge clk); #1;
        check("a_total_writes", 64'(wcnt_a - base_a), 64'(A_TOTAL));
        phase = 2; base_a = wcnt_a;
        bus_a.start = 1'b1;
        @(posedge clk); #1;
        bus_a.start = 1'b0;
        check("a_b2b_busy", 64'(bus_a.busy), 64'd1);
        idx_a = 0;
        stream_a(20001, -1);

        // Asynchronous abort right after word 20000 is accepted
        check("a_pending_wr_en",   64'(bus_a.wr_en),   64'd1);
        check("a_pending_wr_data", 64'(bus_a.wr_data), 64'd20000);
        #2;
        resetn_a = 1'b0;
        #1;
        check("abort_s_ready", 64'(bus_a.s_ready), 64'd0);
        check("abort_wr_en",   64'(bus_a.wr_en),   64'd0);
        check("abort_wr_bank", 64'(bus_a.wr_bank), 64'd0);
        check("abort_wr_addr", 64'(bus_a.wr_addr), 64'd0);
        check("abort_wr_data", 64'(bus_a.wr_data), 64'd0);
        check("abort_busy",    64'(bus_a.busy),    64'd0);
        check("abort_done",    64'(bus_a.done),    64'd0);
        repeat (2) @(posedge clk);
        #1;
        resetn_a = 1'b1;

        // Fresh load after the abort starts again at bank 0, addr 0
        @(posedge clk); #1;
        phase = 3; base_a = wcnt_a;
        bus_a.start = 1'b1;
        @(posedge clk); #1;
        bus_a.start = 1'b0;
        idx_a = 0;
        stream_a(5, -1);
        repeat (3) @(posedge clk);
        #1;
        check("a_restart_writes", 64'(wcnt_a - base_a), 64'd5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
